// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS-7 definitions for the generator and checker.
//   PRBS7_TAPS  - history taps feeding the prediction (h[6] and h[0])
//   PRBS7_SEED  - generator reset seed
//   checker_state_t - checker FSM states
//   prbs7_predict() - next-bit prediction from a 7-bit history (h[0] newest)
package prbs_pkg;

  localparam logic [6:0] PRBS7_TAPS = 7'b100_0001;
  localparam logic [6:0] PRBS7_SEED = 7'd1;

  typedef enum logic [1:0] {
    FILL,
    SEARCH,
    LOCKED
  } checker_state_t;

  // b[n] = b[n-1] ^ b[n-7]
  function automatic logic prbs7_predict(input logic [6:0] hist);
    return ^(hist & PRBS7_TAPS);
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: saturating up-counter with synchronous clear.
//   i_clk, i_arst - clock, asynchronous active-high reset
//   i_inc         - count up by one (holds at all-ones)
//   i_clr         - clear; clear together with inc loads 1
//   o_count       - registered count
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= i_inc ? W'(1) : '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising serial PRBS-7 (1 + X + X^7) checker.
//   i_clk, i_arst  - clock, asynchronous active-high reset
//   i_valid        - i_bit carries a new stream bit this cycle
//   i_bit          - received stream bit
//   i_clearCount   - synchronous clear of o_errorCount (works with i_valid low)
//   o_locked       - checker locked to the stream
//   o_errorPulse   - one-cycle pulse per bit error seen while locked
//   o_errorCount   - saturating count of errors seen while locked
// FILL loads 7 bits of history, SEARCH needs LOCK_COUNT consecutive correct
// predictions on a non-zero history, LOCKED freewheels the history and drops
// back to SEARCH when UNLOCK_ERRORS errors land in one WINDOW-bit window.
module prbs7_checker #(
  parameter int LOCK_COUNT    = 16,
  parameter int WINDOW        = 64,
  parameter int UNLOCK_ERRORS = 4,
  parameter int ERR_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_clearCount,
  output logic             o_locked,
  output logic             o_errorPulse,
  output logic [ERR_W-1:0] o_errorCount
);
  import prbs_pkg::*;

  localparam int WIN_W = $clog2(WINDOW);
  localparam int WE_W  = $clog2(WINDOW + 1);
  // Compare against N-1 so the transition happens on the edge that
  // produces the N-th event.
  localparam logic [7:0]      RUN_LAST  = 8'(LOCK_COUNT - 1);
  localparam logic [WE_W-1:0] WERR_LAST = WE_W'(UNLOCK_ERRORS - 1);

  checker_state_t   state;
  logic [6:0]       hist;
  logic [2:0]       fill_cnt;
  logic [7:0]       run_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [WE_W-1:0]  werr_cnt;

  logic pred;
  logic mismatch;
  logic err_locked;

  assign pred       = prbs7_predict(hist);
  assign mismatch   = i_bit ^ pred;
  assign err_locked = i_valid && (state == LOCKED) && mismatch;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state        <= FILL;
      hist         <= '0;
      fill_cnt     <= '0;
      run_cnt      <= '0;
      win_cnt      <= '0;
      werr_cnt     <= '0;
      o_locked     <= 1'b0;
      o_errorPulse <= 1'b0;
    end else begin
      o_errorPulse <= err_locked;
      if (i_valid) begin
        case (state)
          FILL: begin
            hist <= {hist[5:0], i_bit};
            if (fill_cnt == 3'd6) begin
              fill_cnt <= '0;
              state    <= SEARCH;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
          SEARCH: begin
            hist <= {hist[5:0], i_bit};
            // An all-zero history predicts zero forever; never let a
            // stuck-at-zero line build a run.
            if (mismatch || (hist == '0)) begin
              run_cnt <= '0;
            end else if (run_cnt == RUN_LAST) begin
              run_cnt  <= '0;
              win_cnt  <= '0;
              werr_cnt <= '0;
              o_locked <= 1'b1;
              state    <= LOCKED;
            end else begin
              run_cnt <= run_cnt + 8'd1;
            end
          end
          LOCKED: begin
            // Freewheel on our own prediction so one flipped bit is counted
            // once instead of poisoning the next 7 predictions.
            hist    <= {hist[5:0], pred};
            win_cnt <= win_cnt + WIN_W'(1);
            if (mismatch && (werr_cnt == WERR_LAST)) begin
              run_cnt  <= '0;
              o_locked <= 1'b0;
              state    <= SEARCH;
            end else if (win_cnt == '1) begin
              // Error on the wrap edge belongs to the closing window,
              // which is discarded here.
              werr_cnt <= '0;
            end else if (mismatch) begin
              werr_cnt <= werr_cnt + WE_W'(1);
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  prbs_sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_inc   (err_locked),
    .i_clr   (i_clearCount),
    .o_count (o_errorCount)
  );

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: directed bench for prbs7_checker. Vector tables cover
// acquisition, unlock/relock and gated valid; hand-written sequences cover
// window boundaries, clear/error collisions, saturation (ERR_W=4 copy) and
// asynchronous reset.
module tb_prbs7_checker;
  import prbs_pkg::*;

  logic        i_clk;
  logic        i_arst;
  logic        i_valid;
  logic        i_bit;
  logic        i_clearCount;
  logic        clr4;
  logic        o_locked;
  logic        o_errorPulse;
  logic [15:0] o_errorCount;
  logic        locked4;
  logic        pulse4;
  logic [3:0]  count4;

  prbs7_checker dut (
    .i_clk        (i_clk),
    .i_arst       (i_arst),
    .i_valid      (i_valid),
    .i_bit        (i_bit),
    .i_clearCount (i_clearCount),
    .o_locked     (o_locked),
    .o_errorPulse (o_errorPulse),
    .o_errorCount (o_errorCount)
  );

  prbs7_checker #(.ERR_W(4)) dut4 (
    .i_clk        (i_clk),
    .i_arst       (i_arst),
    .i_valid      (i_valid),
    .i_bit        (i_bit),
    .i_clearCount (clr4),
    .o_locked     (locked4),
    .o_errorPulse (pulse4),
    .o_errorCount (count4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic        b;
    logic        c;
    logic        exp_locked;
    logic        exp_pulse;
    logic [15:0] exp_count;
  } vec_t;

  vec_t       tbl[$];
  int         checks   = 0;
  int         failures = 0;
  logic [6:0] g;
  int         pulses;
  int         lost;
  int         gained;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_bit(output logic b);
    b = g[0] ^ g[6];
    g = {g[5:0], b};
  endtask

  task automatic send(input logic v, input logic b, input logic c);
    i_valid      = v;
    i_bit        = b;
    i_clearCount = c;
    @(posedge i_clk);
    #1;
    if (o_errorPulse) pulses++;
    if (!o_locked) lost++;
    if (o_locked) gained++;
  endtask

  // Transmit the next generator bit, optionally inverted.
  task automatic tx(input logic flip);
    logic b;
    next_bit(b);
    send(1'b1, b ^ flip, 1'b0);
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) begin
      send(tbl[i].v, tbl[i].b, tbl[i].c);
      chk($sformatf("%s[%0d].locked", name, i), o_locked, tbl[i].exp_locked);
      chk($sformatf("%s[%0d].pulse", name, i), o_errorPulse, tbl[i].exp_pulse);
      chk($sformatf("%s[%0d].count", name, i), o_errorCount, tbl[i].exp_count);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    i_valid      = 1'b0;
    i_bit        = 1'b0;
    i_clearCount = 1'b0;
    i_arst       = 1'b0;
    #1;
    i_arst = 1'b1;
    #2;
    chk("rst_locked", o_locked, 0);
    chk("rst_pulse", o_errorPulse, 0);
    chk("rst_count", o_errorCount, 0);
    chk("rst_count4", count4, 0);
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
    g      = PRBS7_SEED;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic b;
    logic f;
    clr4 = 1'b0;
    g    = PRBS7_SEED;

    // Stuck-at-zero line never locks.
    do_reset();
    gained = 0;
    for (int i = 0; i < 500; i++) send(1'b1, 1'b0, 1'b0);
    chk("zeros_never_locked", gained, 0);
    chk("zeros_count", o_errorCount, 0);

    // 50% valid: lock after 23 valid bits; invalid cycles carry garbage.
    do_reset();
    b = 1'b0;
    for (int j = 0; j < 46; j++) begin
      if (j % 2 == 0) begin
        next_bit(b);
        tbl.push_back('{1'b1, b, 1'b0, (j >= 44), 1'b0, 16'd0});
      end else begin
        tbl.push_back('{1'b0, ~b, 1'b0, (j >= 44), 1'b0, 16'd0});
      end
    end
    run_tbl("gated");

    // Clean acquisition, 4 errors in a window -> unlock, 16 bits -> relock.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      next_bit(b);
      tbl.push_back('{1'b1, b, 1'b0, (i == 22), 1'b0, 16'd0});
    end
    for (int k = 0; k < 8; k++) begin
      next_bit(b);
      f = (k % 2 == 1);
      tbl.push_back('{1'b1, b ^ f, 1'b0, (k != 7), f, 16'((k + 1) / 2)});
    end
    for (int k = 0; k < 16; k++) begin
      next_bit(b);
      tbl.push_back('{1'b1, b, 1'b0, (k == 15), 1'b0, 16'd4});
    end
    run_tbl("acq");
    chk("acq_count4", count4, 4);

    // 3 errors in window 0 and 3 in window 1 of the new lock: stay locked.
    pulses = 0;
    lost   = 0;
    for (int k = 0; k < 128; k++)
      tx(k == 10 || k == 20 || k == 30 || k == 70 || k == 80 || k == 90);
    chk("w33_lost", lost, 0);
    chk("w33_pulses", pulses, 6);
    chk("w33_count", o_errorCount, 10);

    // Errors at window positions 60..63: the wrap-edge error is the 4th.
    for (int k = 0; k < 64; k++) begin
      tx(k >= 60);
      if (k == 62) chk("wrap_pre_locked", o_locked, 1);
    end
    chk("wrap_unlock", o_locked, 0);
    chk("wrap_pulse", o_errorPulse, 1);
    chk("wrap_count", o_errorCount, 14);
    for (int k = 0; k < 16; k++) begin
      tx(1'b0);
      if (k == 14) chk("relock_early", o_locked, 0);
    end
    chk("relock", o_locked, 1);
    chk("relock_count4", count4, 14);

    // Clear alone, with i_valid low.
    send(1'b0, 1'b0, 1'b1);
    chk("clr_count", o_errorCount, 0);
    chk("clr_locked", o_locked, 1);
    chk("clr_count4", count4, 14);

    // Long clean run.
    pulses = 0;
    lost   = 0;
    for (int k = 0; k < 1000; k++) tx(1'b0);
    chk("clean_pulses", pulses, 0);
    chk("clean_lost", lost, 0);
    chk("clean_count", o_errorCount, 0);

    // Single flip: one pulse, no follow-on errors.
    pulses = 0;
    tx(1'b1);
    chk("single_pulse", o_errorPulse, 1);
    chk("single_count", o_errorCount, 1);
    chk("single_locked", o_locked, 1);
    for (int k = 0; k < 100; k++) tx(1'b0);
    chk("single_total_pulses", pulses, 1);
    chk("single_count_after", o_errorCount, 1);

    // Clear coincident with an error.
    tx(1'b1);
    chk("pre_clr_count", o_errorCount, 2);
    for (int k = 0; k < 10; k++) tx(1'b0);
    next_bit(b);
    send(1'b1, ~b, 1'b1);
    chk("clr_err_count", o_errorCount, 1);
    chk("clr_err_pulse", o_errorPulse, 1);

    // Sparse errors: stays locked; ERR_W=4 copy saturates at 15.
    lost = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 35; k++) tx(1'b0);
      tx(1'b1);
    end
    chk("sparse_lost", lost, 0);
    chk("sparse_count", o_errorCount, 7);
    chk("sat_count4", count4, 15);
    chk("sat_locked4", locked4, 1);

    // Asynchronous reset while locked, away from any clock edge.
    i_arst = 1'b1;
    #2;
    chk("arst_locked", o_locked, 0);
    chk("arst_count", o_errorCount, 0);
    chk("arst_count4", count4, 0);
    i_arst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Serial PRBS-7 checker (polynomial 1 + X + X^7) sitting directly downstream of the 7-bit PRBS generator, normally across a loopback or link under test. It self-synchronises to the incoming bit stream, declares lock after a run of correct predictions and counts bit errors while locked. It drops lock when the error density exceeds a threshold. Drives board LEDs and seven-segment error display.

## Interface
- LOCK_COUNT, 16: consecutive correct predictions required to lock (2..255)
- WINDOW, 64: unlock observation window in valid bits (power of two, 8..256)
- UNLOCK_ERRORS, 4: errors within one window that force unlock (1..WINDOW)
- ERR_W, 16: error counter width
- i_clk  in  1  clock
- i_arst  in  1  reset; asynchronous, active-high
- i_valid  in  1  i_bit is a new stream bit this cycle
- i_bit  in  1  received stream bit
- i_clearCount  in  1  synchronous clear of o_errorCount
- o_locked  out  1  checker locked to the stream
- o_errorPulse  out  1  one-cycle pulse per detected bit error while locked
- o_errorCount  out  ERR_W  saturating error count

## Operation
- Stream law: b[n] = b[n-1] ^ b[n-7]. History register h[6:0], h[0] = newest bit. Prediction p = h[0] ^ h[6].
- All state advances only on i_valid = 1; i_valid = 0 freezes everything except i_clearCount.
- States: FILL, SEARCH, LOCKED.
- FILL: shift i_bit into h. After 7 valid bits, go to SEARCH.
- SEARCH: shift i_bit into h. Compare i_bit with p.
  - On match with h != 0, increment the run counter.
  - On mismatch, clear the run counter.
  - When h == 0, clear the run counter. This gives stuck-at-zero rejection.
  - When a match brings the run to LOCK_COUNT, go to LOCKED, clear the window and window-error counters, and set o_locked.
- LOCKED: shift p, not i_bit, into h. The history freewheels, so a single error produces exactly one error and is not multiplied.
  - On mismatch: pulse o_errorPulse, increment o_errorCount (saturate at 2^ERR_W−1), increment the window-error count.
  - The window counter counts valid bits. On wrap it clears the window-error count.
  - When the window-error count reaches UNLOCK_ERRORS, go to SEARCH, clear o_locked, clear the run counter and keep h.
- The error counter does not change outside LOCKED.
- i_clearCount together with an error in the same cycle gives o_errorCount = 1.
- i_clearCount alone gives o_errorCount = 0.

## Timing
- Reset values: state FILL, h = 0, all counters 0, o_locked = 0, o_errorPulse = 0, o_errorCount = 0.
- All outputs are registered.
- o_errorPulse is high in the cycle after the clock edge that samples the errored valid bit.
- o_locked rises in the cycle after the edge that samples the LOCK_COUNT-th consecutive match.
- Minimum lock latency from reset with a clean stream: 7 + LOCK_COUNT valid bits.
- The unlock edge is the same edge that counts the UNLOCK_ERRORS-th window error. That error also pulses and is counted.
- Window-wrap edge coinciding with an error: the error counts toward the closing window, then the count clears. If that error reaches the threshold, unlock takes priority.
- Reset mid-operation returns to FILL immediately and asynchronously. o_errorCount is lost.

## Structure
- Package prbs_pkg:
  - PRBS7_TAPS constant (taps 6 and 0)
  - PRBS7_SEED = 7'd1, shared with the generator
  - typedef enum checker_state_t {FILL, SEARCH, LOCKED}
- Sub-module prbs_sat_counter: parameterised width, with inc, clr (clr + inc gives 1) and saturation. Used for o_errorCount.

## Test plan
- Clean generator stream from seed 7'd1, i_valid always 1 -> o_locked = 1 after exactly 23 valid bits; o_errorCount stays 0 over 1000 bits.
- Locked, flip one bit -> exactly one o_errorPulse; o_errorCount = 1; o_locked remains 1; no follow-on errors.
- Locked, 4 flips within 64 bits -> o_locked falls on the 4th error with o_errorCount = 4, then relocks 16 clean bits later.
- Locked, 3 flips in one window and 3 in the next -> stays locked; o_errorCount = 6.
- i_bit held 0 for 500 bits -> never locks; o_errorCount = 0.
- i_valid toggling 50% with a clean stream -> lock after 23 valid bits. i_clearCount coincident with an error -> o_errorCount = 1. With ERR_W = 4 and 20 errors -> o_errorCount saturates at 15.
